// File: rtl/fica_pkg.sv
// Shared fixed-point types and helpers for the FastICA datapath (Q12.13, 26-bit signed).
package fica_pkg;

  localparam int DW   = 26;
  localparam int FRAC = 13;

  typedef logic signed [DW-1:0] fx_t;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    DRAIN,
    SCALE,
    DONE
  } state_t;

  localparam fx_t FX_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam fx_t FX_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [63:0] FX_MAX_W = 64'(FX_MAX);
  localparam logic signed [63:0] FX_MIN_W = 64'(FX_MIN);

  // Clamp a wide signed intermediate into the fx_t range.
  function automatic fx_t sat_fx(input logic signed [63:0] x);
    if (x > FX_MAX_W)
      sat_fx = FX_MAX;
    else if (x < FX_MIN_W)
      sat_fx = FX_MIN;
    else
      sat_fx = x[DW-1:0];
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One vector component: full-precision z*g product register feeding a wide accumulator.
module mac_lane #(
  parameter int DW = 26,
  parameter int AW = 62
) (
  input  logic                 clk_upd,
  input  logic                 rstn_upd,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] z,
  input  logic signed [DW-1:0] g,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] p;
  logic                   v1;

  always_ff @(posedge clk_upd) begin
    if (!rstn_upd) begin
      p   <= '0;
      v1  <= 1'b0;
      acc <= '0;
    end else if (clr) begin
      v1  <= 1'b0;
      acc <= '0;
    end else begin
      v1 <= en;
      if (en)
        p <= (2*DW)'(z) * (2*DW)'(g);
      // AW leaves LOG2_N guard bits above the product, so N sums never wrap.
      if (v1)
        acc <= acc + AW'(p);
    end
  end

endmodule

// File: rtl/w_update_acc.sv
// One-unit FastICA update: accumulates E{z*g} over N samples, then w_new = E{z*g} - 3w.
//
// state | meaning
// IDLE  | waiting for start; latches w and clears lanes on start
// ACC   | accepting in_valid samples until the Nth
// DRAIN | last product lands in the accumulators
// SCALE | mean, -3w and saturation registered into w_new
// DONE  | out_valid pulse, then back to IDLE
module w_update_acc import fica_pkg::*; #(
  parameter int DW     = fica_pkg::DW,
  parameter int FRAC   = fica_pkg::FRAC,
  parameter int LOG2_N = 10
) (
  input  logic                 clk_upd,
  input  logic                 rstn_upd,
  input  logic                 start,
  input  logic signed [DW-1:0] w1,
  input  logic signed [DW-1:0] w2,
  input  logic signed [DW-1:0] w3,
  input  logic signed [DW-1:0] w4,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] zi1,
  input  logic signed [DW-1:0] zi2,
  input  logic signed [DW-1:0] zi3,
  input  logic signed [DW-1:0] zi4,
  input  logic signed [DW-1:0] g,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [DW-1:0] w_new1,
  output logic signed [DW-1:0] w_new2,
  output logic signed [DW-1:0] w_new3,
  output logic signed [DW-1:0] w_new4
);

  localparam int AW = 2*DW + LOG2_N;
  localparam int SH = LOG2_N + FRAC;
  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};

  state_t              state;
  logic [LOG2_N-1:0]   cnt;
  logic signed [DW-1:0] w_lat [4];
  logic signed [DW-1:0] zi    [4];
  logic signed [AW-1:0] acc   [4];
  fx_t                  r_sat [4];
  logic                 clr;
  logic                 en;

  assign clr = (state == IDLE) && start;
  assign en  = (state == ACC) && in_valid;

  assign zi[0] = zi1;
  assign zi[1] = zi2;
  assign zi[2] = zi3;
  assign zi[3] = zi4;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic signed [AW-1:0] m;
    logic signed [DW+1:0] t;

    mac_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk_upd  (clk_upd),
      .rstn_upd (rstn_upd),
      .clr      (clr),
      .en       (en),
      .z        (zi[k]),
      .g        (g),
      .acc      (acc[k])
    );

    // Mean and Q-format rescale collapse into one floor shift.
    assign m        = acc[k] >>> SH;
    assign t        = (DW+2)'(w_lat[k]) + ((DW+2)'(w_lat[k]) <<< 1);
    assign r_sat[k] = sat_fx(64'(m) - 64'(t));
  end

  always_ff @(posedge clk_upd) begin
    if (!rstn_upd) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      w_new1    <= '0;
      w_new2    <= '0;
      w_new3    <= '0;
      w_new4    <= '0;
      for (int k = 0; k < 4; k++) w_lat[k] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w_lat[0] <= w1;
            w_lat[1] <= w2;
            w_lat[2] <= w3;
            w_lat[3] <= w4;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= DRAIN;
          end
        end
        DRAIN: state <= SCALE;
        SCALE: begin
          w_new1    <= r_sat[0];
          w_new2    <= r_sat[1];
          w_new3    <= r_sat[2];
          w_new4    <= r_sat[3];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w_update_acc.sv
// Directed bench for w_update_acc at N=4: vector table plus gap, stray-input and reset sequences.
module tb_w_update_acc;

  localparam int DW = 26;

  logic clk_upd = 1'b0;
  logic rstn_upd, start, in_valid;
  logic signed [DW-1:0] w1, w2, w3, w4, zi1, zi2, zi3, zi4, g;
  logic signed [DW-1:0] w_new1, w_new2, w_new3, w_new4;
  logic busy, out_valid;

  always #5 clk_upd = ~clk_upd;

  w_update_acc #(.DW(26), .FRAC(13), .LOG2_N(2)) dut (
    .clk_upd   (clk_upd),
    .rstn_upd  (rstn_upd),
    .start     (start),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .w4        (w4),
    .in_valid  (in_valid),
    .zi1       (zi1),
    .zi2       (zi2),
    .zi3       (zi3),
    .zi4       (zi4),
    .g         (g),
    .busy      (busy),
    .out_valid (out_valid),
    .w_new1    (w_new1),
    .w_new2    (w_new2),
    .w_new3    (w_new3),
    .w_new4    (w_new4)
  );

  typedef struct {
    string nm;
    int    w[4];
    int    z[4];
    int    gv;
    int    e[4];
  } vec_t;

  vec_t tbl[5];
  int n_tot = 0;
  int n_bad = 0;
  int ov_cnt = 0;

  always @(posedge clk_upd) if (out_valid === 1'b1) ov_cnt++;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_sample(input int z0, input int z1, input int z2, input int z3, input int gv);
    zi1 = DW'(z0); zi2 = DW'(z1); zi3 = DW'(z2); zi4 = DW'(z3); g = DW'(gv);
    in_valid = 1'b1;
    @(negedge clk_upd);
    in_valid = 1'b0;
  endtask

  task automatic do_start(input int a, input int b, input int c, input int d);
    w1 = DW'(a); w2 = DW'(b); w3 = DW'(c); w4 = DW'(d);
    start = 1'b1;
    @(negedge clk_upd);
    start = 1'b0;
  endtask

  // Called at the negedge right after the Nth sample's accepting edge.
  task automatic check_done(input string nm, input int e0, input int e1, input int e2, input int e3);
    int lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      @(negedge clk_upd);
      lat++;
    end
    chk({nm, " latency"}, lat, 3);
    chk({nm, " busy@ov"}, busy, 1);
    chk({nm, " w_new1"}, w_new1, e0);
    chk({nm, " w_new2"}, w_new2, e1);
    chk({nm, " w_new3"}, w_new3, e2);
    chk({nm, " w_new4"}, w_new4, e3);
    @(negedge clk_upd);
    chk({nm, " ov pulse"}, out_valid, 0);
    chk({nm, " busy end"}, busy, 0);
    chk({nm, " w_new1 held"}, w_new1, e0);
  endtask

  initial begin
    int ov0;
    tbl[0] = '{"basic", '{0, 0, 0, 0}, '{8192, 0, 0, 0}, 8192, '{8192, 0, 0, 0}};
    tbl[1] = '{"minus3w", '{4096, 4096, -4096, 0}, '{8192, 8192, 8192, 8192}, 8192,
               '{-4096, -4096, 20480, 8192}};
    tbl[2] = '{"sat", '{0, 0, 0, 0}, '{16777216, -16777216, 0, 0}, 16777216,
               '{33554431, -33554432, 0, 0}};
    tbl[3] = '{"mixed", '{8192, 0, 0, 0}, '{8192, -8192, 4096, 0}, 8192,
               '{-16384, -8192, 4096, 0}};
    tbl[4] = '{"floor", '{0, 0, 0, 0}, '{1, -1, 0, 0}, 1, '{0, -1, 0, 0}};

    rstn_upd = 1'b0; start = 1'b0; in_valid = 1'b0;
    w1 = '0; w2 = '0; w3 = '0; w4 = '0;
    zi1 = '0; zi2 = '0; zi3 = '0; zi4 = '0; g = '0;
    @(negedge clk_upd);
    @(negedge clk_upd);
    chk("rst busy", busy, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst w_new1", w_new1, 0);
    chk("rst w_new4", w_new4, 0);
    rstn_upd = 1'b1;
    @(negedge clk_upd);

    for (int i = 0; i < 5; i++) begin
      ov0 = ov_cnt;
      do_start(tbl[i].w[0], tbl[i].w[1], tbl[i].w[2], tbl[i].w[3]);
      chk({tbl[i].nm, " busy start"}, busy, 1);
      for (int s = 0; s < 4; s++) begin
        drive_sample(tbl[i].z[0], tbl[i].z[1], tbl[i].z[2], tbl[i].z[3], tbl[i].gv);
        chk({tbl[i].nm, " busy acc"}, busy, 1);
      end
      check_done(tbl[i].nm, tbl[i].e[0], tbl[i].e[1], tbl[i].e[2], tbl[i].e[3]);
      @(negedge clk_upd);
      chk({tbl[i].nm, " ov count"}, ov_cnt - ov0, 1);
    end

    // Stray samples before start, gaps of 0-3 cycles, ignored start during ACC.
    ov0 = ov_cnt;
    for (int s = 0; s < 3; s++) drive_sample(8192, 0, 0, 0, 8192);
    chk("gaps idle busy", busy, 0);
    do_start(0, 0, 0, 0);
    drive_sample(8192, 0, 0, 0, 8192);
    for (int s = 0; s < 3; s++) begin
      for (int q = 0; q < 3 - s; q++) begin
        if (q == 0) begin
          w1 = DW'(8192); w2 = DW'(8192); w3 = DW'(8192); w4 = DW'(8192);
          start = 1'b1;
        end
        @(negedge clk_upd);
        start = 1'b0;
      end
      drive_sample(8192, 0, 0, 0, 8192);
    end
    check_done("gaps", 8192, 0, 0, 0);
    @(negedge clk_upd);
    chk("gaps ov count", ov_cnt - ov0, 1);

    // start with in_valid in IDLE: that sample must not count.
    ov0 = ov_cnt;
    zi1 = DW'(8192); zi2 = '0; zi3 = '0; zi4 = '0; g = DW'(8192);
    in_valid = 1'b1;
    do_start(0, 0, 0, 0);
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) drive_sample(8192, 0, 0, 0, 8192);
    repeat (5) @(negedge clk_upd);
    chk("startval early ov", ov_cnt - ov0, 0);
    chk("startval busy", busy, 1);
    drive_sample(8192, 0, 0, 0, 8192);
    check_done("startval", 8192, 0, 0, 0);

    // Reset mid-ACC abandons the run.
    ov0 = ov_cnt;
    do_start(0, 0, 0, 0);
    drive_sample(8192, 0, 0, 0, 8192);
    drive_sample(8192, 0, 0, 0, 8192);
    rstn_upd = 1'b0;
    @(negedge clk_upd);
    rstn_upd = 1'b1;
    chk("midrst busy", busy, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst w_new1", w_new1, 0);
    repeat (6) @(negedge clk_upd);
    chk("midrst no ov", ov_cnt - ov0, 0);
    do_start(0, 0, 0, 0);
    for (int s = 0; s < 4; s++) drive_sample(8192, 0, 0, 0, 8192);
    check_done("after rst", 8192, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
